// File: rtl/pipe_credit_drain.sv
// Credit-gated receiver for a fixed-latency delay line: tail words land in a FWFT FIFO.
// Arrival is visible one cycle after its edge; consumer backpressure is absorbed by withholding credits.
module pipe_credit_drain #(
  parameter int DATA  = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ok,
  input  logic            pipe_valid,
  input  logic [DATA-1:0] pipe_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   inflight,
  output logic            err_overflow,
  output logic            err_unexpected
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, inflight_q, inflight_d, credits_q, credits_d;
  logic            err_ovf_q, err_ovf_d, err_unx_q, err_unx_d;
  logic            issue_fire, arrive, pop, wr_en;

  always_comb begin
    issue_fire = issue_valid && (credits_q != '0);
    arrive     = pipe_valid;
    pop        = out_ready && (count_q != '0);
    // A full FIFO still takes an arrival when the head leaves in the same cycle.
    wr_en      = arrive && ((count_q != FULL) || pop);

    count_d    = count_q + CW'(wr_en) - CW'(pop);
    inflight_d = inflight_q + CW'(issue_fire) - CW'(arrive && (inflight_q != '0));
    credits_d  = credits_q - CW'(issue_fire) + CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    err_ovf_d  = err_ovf_q | (arrive && !wr_en);
    err_unx_d  = err_unx_q | (arrive && (inflight_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      inflight_q <= '0;
      credits_q  <= FULL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_ovf_q  <= 1'b0;
      err_unx_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      credits_q  <= credits_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_ovf_q  <= err_ovf_d;
      err_unx_q  <= err_unx_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pipe_data;
  end

  assign issue_ok       = (credits_q != '0);
  assign out_valid      = (count_q != '0);
  assign out_data       = mem_q[rd_ptr_q];
  assign count          = count_q;
  assign inflight       = inflight_q;
  assign err_overflow   = err_ovf_q;
  assign err_unexpected = err_unx_q;

endmodule

// File: tb/tb_pipe_credit_drain.sv
// Bench for pipe_credit_drain: latency-8 delay-line model feeding the DUT, scoreboard of buffered words.
module tb_pipe_credit_drain;

  logic        clk = 1'b0;
  logic        reset, issue_valid, issue_ok, pipe_valid, out_valid, out_ready;
  logic        err_overflow, err_unexpected;
  logic [31:0] pipe_data, out_data;
  logic [4:0]  count, inflight;

  always #5 clk = ~clk;

  pipe_credit_drain dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ok(issue_ok),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count), .inflight(inflight),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected)
  );

  typedef struct { logic [31:0] d; int ic; } ent_t;
  typedef struct {
    logic iv, ordy, injv; logic [31:0] injd;
    logic ok, vld; int cnt, inf; logic dchk; logic [31:0] dat;
  } vec_t;

  int asserts = 0, fails = 0;
  int m_cred = 16, m_inf = 0, cyc = 0, fires = 0, pops = 0, word = 0;
  bit m_ovf = 0, m_unx = 0, known = 0, lat_chk = 0, inv_chk = 0;
  ent_t mq[$];
  bit sr_v[8];
  logic [31:0] sr_d[8];
  int sr_c[8];
  logic cur_iv, cur_ordy, cur_injv, cur_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs and compare against the model away from the edge.
  task automatic sample(input logic iv, input logic ordy, input logic injv,
                        input logic [31:0] injd, input logic rst);
    issue_valid = iv; out_ready = ordy; reset = rst;
    pipe_valid  = injv | sr_v[7];
    pipe_data   = injv ? injd : sr_d[7];
    cur_iv = iv; cur_ordy = ordy; cur_injv = injv; cur_rst = rst;
    #3;
    if (known) begin
      chk("issue_ok", issue_ok, m_cred != 0);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("inflight", inflight, m_inf);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_unexpected", err_unexpected, m_unx);
      if (mq.size() != 0) chk("out_data", out_data, mq[0].d);
      if (inv_chk) chk("invariant", m_cred + int'(inflight) + int'(count), 16);
    end
  endtask

  task automatic advance();
    int fire, pp, arr, wr;
    ent_t e;
    fire = 0;
    if (cur_rst) begin
      fire = int'(cur_iv && m_cred != 0);
      pp   = int'(cur_ordy && mq.size() != 0);
      arr  = int'(pipe_valid);
      wr   = int'(arr != 0 && (mq.size() != 16 || pp != 0));
      if (pp != 0) begin
        e = mq.pop_front();
        pops++;
        if (lat_chk) chk("latency", cyc - e.ic, 9);
      end
      if (wr != 0) begin
        e.d  = pipe_data;
        e.ic = cur_injv ? -1 : sr_c[7];
        mq.push_back(e);
      end
      if (arr != 0 && m_inf == 0) m_unx = 1;
      if (arr != 0 && wr == 0) m_ovf = 1;
      m_inf  = m_inf + fire - int'(arr != 0 && m_inf != 0);
      m_cred = m_cred - fire + pp;
      fires += fire;
    end else begin
      mq.delete();
      m_cred = 16; m_inf = 0; m_ovf = 0; m_unx = 0; known = 1;
    end
    for (int i = 7; i > 0; i--) begin
      sr_v[i] = sr_v[i-1]; sr_d[i] = sr_d[i-1]; sr_c[i] = sr_c[i-1];
    end
    sr_v[0] = (fire != 0); sr_d[0] = word; sr_c[0] = cyc;
    if (fire != 0) word++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step(input logic iv, input logic ordy, input logic injv,
                      input logic [31:0] injd, input logic rst);
    sample(iv, ordy, injv, injd, rst);
    advance();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, ordy, 1'b0, 32'h0, 1'b1);
  endtask

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 0, 0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'hA1A1,   1'b1, 1'b0, 0, 1, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'hA2A2,   1'b1, 1'b1, 1, 1, 1'b1, 32'hA1A1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 2, 0, 1'b1, 32'hA1A1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 1'b1, 1, 0, 1'b1, 32'hA2A2};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 0, 0, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 0, 0, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin sr_v[i] = 0; sr_d[i] = '0; sr_c[i] = 0; end
    issue_valid = 0; out_ready = 0; pipe_valid = 0; pipe_data = '0; reset = 0;
    @(posedge clk); #1;

    // Reset then idle
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_issue_ok", issue_ok, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_inflight", inflight, 5'd0);
    advance();
    idle(10, 1'b1);
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("idle_count", count, 5'd0);
    chk("idle_issue_ok", issue_ok, 1'b1);
    advance();

    // Directed vectors with injected arrivals
    for (int i = 0; i < 7; i++) begin
      sample(tbl[i].iv, tbl[i].ordy, tbl[i].injv, tbl[i].injd, 1'b1);
      chk($sformatf("vec%0d_issue_ok", i), issue_ok, tbl[i].ok);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].vld);
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d_inflight", i), inflight, tbl[i].inf);
      chk($sformatf("vec%0d_err_unexpected", i), err_unexpected, 1'b0);
      if (tbl[i].dchk) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].dat);
      advance();
    end
    idle(16, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming, latency 8, consumer always ready
    fires = 0; pops = 0; word = 0; lat_chk = 1;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(12, 1'b1);
    lat_chk = 0;
    chk("stream_fires", fires, 100);
    chk("stream_pops", pops, 100);
    chk("stream_err_overflow", err_overflow, 1'b0);
    chk("stream_err_unexpected", err_unexpected, 1'b0);

    // Backpressure fill then single-pop credit return
    fires = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_fires", fires, 16);
    sample(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("bp_issue_ok_low", issue_ok, 1'b0);
    chk("bp_count_full", count, 5'd16);
    chk("bp_inflight_zero", inflight, 5'd0);
    advance();
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp_credit_back", issue_ok, 1'b1);
    chk("bp_count_15", count, 5'd15);
    advance();
    idle(20, 1'b1);

    // Full FIFO arrival with and without a simultaneous pop
    for (int i = 0; i < 26; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    sample(1'b0, 1'b1, 1'b1, 32'hDEAD0001, 1'b1);
    chk("full_pre_count", count, 5'd16);
    advance();
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_pop_no_ovf", err_overflow, 1'b0);
    chk("full_pop_count", count, 5'd16);
    advance();
    step(1'b0, 1'b0, 1'b1, 32'hDEAD0002, 1'b1);
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_ovf_set", err_overflow, 1'b1);
    chk("full_ovf_count", count, 5'd16);
    advance();
    idle(3, 1'b0);
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("full_ovf_sticky", err_overflow, 1'b1);
    advance();
    idle(20, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Unexpected arrival, then reset with 5 buffered and 3 in flight
    step(1'b0, 1'b0, 1'b1, 32'hBAD0, 1'b1);
    sample(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("unx_set", err_unexpected, 1'b1);
    chk("unx_written", count, 5'd1);
    advance();
    for (int i = 0; i < 13; i++)
      step(logic'(i < 5 || (i >= 9 && i < 12)), 1'b0, 1'b0, 32'h0, 1'b1);
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_count5", count, 5'd5);
    chk("mid_inflight3", inflight, 5'd3);
    advance();
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("mid_rst_count", count, 5'd0);
    chk("mid_rst_inflight", inflight, 5'd0);
    chk("mid_rst_unx", err_unexpected, 1'b0);
    chk("mid_rst_issue_ok", issue_ok, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    advance();
    idle(6, 1'b0);
    sample(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("late_unx", err_unexpected, 1'b1);
    chk("late_count", count, 5'd3);
    chk("late_inflight", inflight, 5'd0);
    advance();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Random stalls across many pointer wraps
    fires = 0; pops = 0; inv_chk = 1; n = 0;
    while ((fires < 1000 || mq.size() != 0 || m_inf != 0) && n < 20000) begin
      step(logic'(fires < 1000 ? $urandom_range(0, 1) : 0), logic'($urandom_range(0, 1)),
           1'b0, 32'h0, 1'b1);
      n++;
    end
    inv_chk = 0;
    chk("random_in_budget", n < 20000, 1'b1);
    chk("random_pops", pops, 1000);
    chk("random_err_overflow", err_overflow, 1'b0);
    chk("random_err_unexpected", err_unexpected, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/pipe_credit_drain.md
Name: pipe_credit_drain

Overview:
- Receiving end of a fixed-latency data delay line, such as an NTT butterfly/multiplier pipeline built from delay-register chains.
- Issues credits to the upstream injector so the number of words in flight plus buffered never exceeds buffer capacity.
- Captures words emerging from the pipeline tail into a FIFO.
- Presents the FIFO to a consumer with a valid/ready handshake, absorbing consumer backpressure that the pipeline itself cannot stall for.

Parameters:
- DATA, 32, data word width in bits.
- DEPTH, 16, FIFO capacity in words; legal range 2..256; power of two.
- CW, $clog2(DEPTH+1), width of the count, credit and in-flight counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- issue_valid  in  1  upstream wants to inject one word into the pipeline this cycle.
- issue_ok  out  1  credit available; injection fires when issue_valid && issue_ok.
- pipe_valid  in  1  a word is emerging from the pipeline tail this cycle.
- pipe_data  in  DATA  tail data, qualified by pipe_valid.
- out_valid  out  1  FIFO non-empty; head word presented.
- out_ready  in  1  consumer accepts; pop fires when out_valid && out_ready.
- out_data  out  DATA  FIFO head word (first-word fall-through).
- count  out  CW  words currently buffered.
- inflight  out  CW  words issued but not yet arrived.
- err_overflow  out  1  sticky; pipe_valid arrived while FIFO full.
- err_unexpected  out  1  sticky; pipe_valid arrived while inflight==0.

Behaviour:
- Reset (reset==0 at an edge): count=0, inflight=0, credits=DEPTH, rd/wr pointers=0, both err flags=0. Outputs after reset: out_valid=0, issue_ok=1, out_data don't-care (0 in the bench model). Storage array is not cleared.
- Reset mid-operation discards buffered and in-flight accounting. Words arriving after reset count as unexpected.
- Events per cycle:
  - issue_fire = issue_valid && issue_ok.
  - arrive = pipe_valid.
  - pop = out_valid && out_ready.
- Write enable: wr_en = arrive && (count!=DEPTH || pop). A full FIFO accepts an arrival in the same cycle as a pop.
- Counter updates, all registered:
  - count' = count + wr_en - pop.
  - inflight' = inflight + issue_fire - (arrive && inflight!=0).
  - credits' = credits - issue_fire + pop.
- issue_ok = (credits != 0), combinational from the credits register only. It has no dependency on issue_valid or out_ready in the same cycle.
- Invariant without errors: credits + inflight + count == DEPTH. An arrival moves a unit from inflight to count without touching credits.
- Simultaneous issue_fire and pop with credits==0: issue_ok is 0, so no issue that cycle. The pop's credit is visible next cycle (1-cycle credit return latency).
- FIFO:
  - Circular array of DEPTH x DATA.
  - wr_ptr and rd_ptr wrap modulo DEPTH.
  - out_data = mem[rd_ptr].
  - out_valid = (count != 0).
  - A word arriving at edge t is visible on out_valid/out_data after edge t; there is no same-cycle bypass from pipe_data.
- Empty FIFO: pop cannot fire. out_ready is ignored.
- Overflow (arrive with count==DEPTH and no pop):
  - Word dropped.
  - err_overflow set.
  - count unchanged; inflight still decrements.
- Unexpected (arrive with inflight==0):
  - err_unexpected set.
  - Word still written if space.
  - inflight stays 0.
- Error flags clear only on reset.
- Pipeline latency is external and may be any value ≥1. It does not affect correctness, provided it is fixed and the upstream honours issue_ok.

Test Plan:
- Reset then idle:
  - After reset==0 for 2 cycles then release: issue_ok=1, out_valid=0, count=0, inflight=0.
  - No change over 10 idle cycles.
- Streaming with latency 8 (bench delay model), DEPTH=16, out_ready=1:
  - Issue 100 words 0..99 back-to-back.
  - Output order is 0..99, each word 9 cycles after its issue cycle (8 pipeline + 1 FIFO).
  - issue_ok never drops; err flags stay 0.
- Backpressure fill:
  - out_ready=0, issue continuously.
  - Exactly 16 issue_fires occur, then issue_ok=0.
  - After arrivals: count=16, inflight=0.
  - Raise out_ready for 1 cycle: issue_ok=1 the following cycle, credits=1.
- Pointer wrap with random stalls:
  - 1000 words, issue_valid and out_ready each random at 50%.
  - Data matches a scoreboard in order.
  - credits+inflight+count==16 every cycle.
- Full-FIFO arrival with simultaneous pop:
  - Force count=16 plus an injected extra arrival, with out_ready=1 that cycle: word accepted, no err_overflow.
  - Same with out_ready=0: err_overflow=1 (sticky), word dropped.
- Unexpected arrival and mid-run reset:
  - pipe_valid with inflight==0: err_unexpected=1.
  - Reset asserted mid-stream with 5 buffered and 3 in flight: all counters return to reset values and both err flags clear.
  - The 3 late arrivals set err_unexpected again.
